// File: rtl/write_master_port_pkg.sv
// Shared types and width helpers for the write master port and its ID free list.
package write_master_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  // Width of the transaction ID field; never narrower than one bit.
  function automatic int id_width(input int num_ids);
    return (num_ids < 2) ? 1 : $clog2(num_ids);
  endfunction

  // Width of the beats-minus-one length field; never narrower than one bit.
  function automatic int len_width(input int max_len);
    return (max_len < 2) ? 1 : $clog2(max_len);
  endfunction

endpackage

// File: rtl/write_master_port_id_free_list.sv
// Busy bitmap of outstanding transaction IDs with lowest-free allocation.
module id_free_list
  import write_master_port_pkg::*;
#(
  parameter  int NUM_IDS = 2,
  localparam int IW      = id_width(NUM_IDS)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               alloc,
  input  logic               free,
  input  logic [IW-1:0]      free_id,
  output logic [NUM_IDS-1:0] busy,
  output logic [IW-1:0]      alloc_id,
  output logic               any_free
);

  logic [NUM_IDS-1:0] alloc_mask;
  logic [NUM_IDS-1:0] free_mask;

  // Scan from the top so the lowest free index wins.
  always_comb begin
    alloc_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_id = IW'(i);
    end
    any_free   = ~&busy;
    alloc_mask = alloc ? (NUM_IDS'(1) << alloc_id) : '0;
    free_mask  = free ? (NUM_IDS'(1) << free_id) : '0;
  end

  // Allocation is chosen from the pre-update bitmap, so an ID freed this
  // cycle is never handed out again in the same cycle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~free_mask) | alloc_mask;
    end
  end

endmodule

// File: rtl/write_master_port.sv
// Write master port: accepts a command, requests the AW channel, streams the
// burst beats, and retires transaction IDs as write responses come back.
module write_master_port
  import write_master_port_pkg::*;
#(
  parameter  int ADDR_WIDTH            = 32,
  parameter  int DATA_WIDTH            = 32,
  parameter  int NUM_OUTSTANDING_TRANS = 2,
  parameter  int MAX_BURST_LEN         = 16,
  localparam int IW                    = id_width(NUM_OUTSTANDING_TRANS),
  localparam int LW                    = len_width(MAX_BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LW-1:0]         cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  AW_request,
  output logic [ADDR_WIDTH-1:0] AW_addr,
  output logic [IW-1:0]         AW_id,
  input  logic                  AW_grant,
  output logic                  W_valid,
  output logic [DATA_WIDTH-1:0] W_data,
  output logic                  W_last,
  input  logic                  W_ready,
  input  logic                  B_valid,
  input  logic [IW-1:0]         B_id,
  input  logic [1:0]            B_resp,
  output logic                  B_ready,
  output logic                  done_valid,
  output logic [IW-1:0]         done_id,
  output logic [1:0]            done_resp,
  output logic                  spurious_b,
  output state_t                state
);

  // Handshake rule for every channel here: a transfer happens in exactly the
  // cycle where valid and ready are both high; neither side waits on the other.

  state_t state_q, state_d;
  logic [LW-1:0] len_q;
  logic [LW-1:0] beat_cnt;
  logic [NUM_OUTSTANDING_TRANS-1:0] busy;
  logic [IW-1:0] alloc_id;
  logic any_free;
  logic cmd_fire;
  logic w_fire;
  logic b_hit;
  logic b_miss;

  id_free_list #(
    .NUM_IDS(NUM_OUTSTANDING_TRANS)
  ) u_id_free_list (
    .clk      (clk),
    .clr      (clr),
    .alloc    (cmd_fire),
    .free     (b_hit),
    .free_id  (B_id),
    .busy     (busy),
    .alloc_id (alloc_id),
    .any_free (any_free)
  );

  assign B_ready = 1'b1;
  assign state   = state_q;
  assign b_hit   = B_valid & busy[B_id];
  assign b_miss  = B_valid & ~busy[B_id];

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    AW_request  = 1'b0;
    W_valid     = 1'b0;
    W_data      = '0;
    W_last      = 1'b0;
    wdata_ready = 1'b0;
    cmd_fire    = 1'b0;
    w_fire      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low while reset is asserted so the port never accepts in reset.
        cmd_ready = clr & any_free;
        cmd_fire  = cmd_valid & cmd_ready;
        if (cmd_fire) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        AW_request = 1'b1;
        if (AW_grant) state_d = ST_DATA;
      end
      ST_DATA: begin
        W_valid     = wdata_valid;
        W_data      = wdata;
        wdata_ready = W_ready;
        W_last      = (beat_cnt == len_q);
        w_fire      = W_valid & W_ready;
        if (w_fire && W_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      AW_addr    <= '0;
      AW_id      <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_resp  <= '0;
      spurious_b <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        AW_addr <= cmd_addr;
        AW_id   <= alloc_id;
        len_q   <= cmd_len;
      end
      if (w_fire) beat_cnt <= W_last ? '0 : beat_cnt + 1'b1;
      done_valid <= b_hit;
      if (b_hit) begin
        done_id   <= B_id;
        done_resp <= B_resp;
      end
      if (b_miss) spurious_b <= 1'b1;
    end
  end

endmodule

// File: tb/tb_write_master_port.sv
// Directed bench for write_master_port: burst flow, ID reuse, backpressure,
// spurious responses and mid-burst reset.
module tb_write_master_port;
  import write_master_port_pkg::*;

  logic        clk;
  logic        clr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        AW_request;
  logic [31:0] AW_addr;
  logic [0:0]  AW_id;
  logic        AW_grant;
  logic        W_valid;
  logic [31:0] W_data;
  logic        W_last;
  logic        W_ready;
  logic        B_valid;
  logic [0:0]  B_id;
  logic [1:0]  B_resp;
  logic        B_ready;
  logic        done_valid;
  logic [0:0]  done_id;
  logic [1:0]  done_resp;
  logic        spurious_b;
  state_t      dbg_state;

  int passed = 0;
  int total  = 0;

  write_master_port dut (
    .clk         (clk),
    .clr         (clr),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .AW_request  (AW_request),
    .AW_addr     (AW_addr),
    .AW_id       (AW_id),
    .AW_grant    (AW_grant),
    .W_valid     (W_valid),
    .W_data      (W_data),
    .W_last      (W_last),
    .W_ready     (W_ready),
    .B_valid     (B_valid),
    .B_id        (B_id),
    .B_resp      (B_resp),
    .B_ready     (B_ready),
    .done_valid  (done_valid),
    .done_id     (done_id),
    .done_resp   (done_resp),
    .spurious_b  (spurious_b),
    .state       (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Driver: offer a command, wait gw cycles, then grant the address channel.
  task automatic send_cmd(input logic [31:0] a, input logic [3:0] l, input int gw,
                          input logic [0:0] exp_id);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    #1 chk("cmd_ready_offer", cmd_ready, 1'b1);
    cyc();
    cmd_valid = 1'b0;
    #1;
    chk("aw_request_up", AW_request, 1'b1);
    chk("aw_id", AW_id, exp_id);
    chk("aw_addr", AW_addr, a);
    chk("cmd_ready_addr", cmd_ready, 1'b0);
    repeat (gw) begin
      cyc();
      chk("aw_request_hold", AW_request, 1'b1);
    end
    AW_grant = 1'b1;
    cyc();
    AW_grant = 1'b0;
    #1;
    chk("aw_request_down", AW_request, 1'b0);
    chk("state_data", dbg_state, ST_DATA);
  endtask

  // Driver: stream l+1 beats with W_ready held high.
  task automatic run_beats(input logic [3:0] l, input logic [31:0] base);
    for (int i = 0; i <= int'(l); i++) begin
      wdata_valid = 1'b1;
      wdata       = base + 32'(i);
      W_ready     = 1'b1;
      #1;
      chk("w_valid", W_valid, 1'b1);
      chk("w_data", W_data, base + 32'(i));
      chk("w_last", W_last, (i == int'(l)));
      cyc();
    end
    wdata_valid = 1'b0;
    W_ready     = 1'b0;
    #1 chk("state_idle_after_burst", dbg_state, ST_IDLE);
  endtask

  task automatic send_b(input logic [0:0] id, input logic [1:0] resp);
    B_valid = 1'b1;
    B_id    = id;
    B_resp  = resp;
    cyc();
    B_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic pat [5];
    int   sent;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    clr = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; AW_grant = 1'b0; W_ready = 1'b0;
    B_valid = 1'b0; B_id = '0; B_resp = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_aw_request", AW_request, 1'b0);
    chk("rst_aw_addr", AW_addr, 32'h0);
    chk("rst_aw_id", AW_id, 1'b0);
    chk("rst_w_valid", W_valid, 1'b0);
    chk("rst_w_last", W_last, 1'b0);
    chk("rst_done_valid", done_valid, 1'b0);
    chk("rst_done_id", done_id, 1'b0);
    chk("rst_done_resp", done_resp, 2'd0);
    chk("rst_spurious", spurious_b, 1'b0);
    chk("rst_b_ready", B_ready, 1'b1);
    chk("rst_state", dbg_state, ST_IDLE);
    clr = 1'b1;
    #1 chk("idle_cmd_ready", cmd_ready, 1'b1);

    // Spurious response while idle with nothing outstanding
    send_b(1'b1, RESP_OKAY);
    chk("spur_flag", spurious_b, 1'b1);
    chk("spur_no_done", done_valid, 1'b0);
    cyc();
    chk("spur_sticky", spurious_b, 1'b1);

    // Single burst, grant two cycles into the request
    send_cmd(32'h0001_0040, 4'd3, 2, 1'b0);
    run_beats(4'd3, 32'hA0);
    chk("single_cmd_ready", cmd_ready, 1'b1);
    send_b(1'b0, RESP_OKAY);
    chk("single_done_valid", done_valid, 1'b1);
    chk("single_done_id", done_id, 1'b0);
    chk("single_done_resp", done_resp, 2'd0);
    cyc();
    chk("single_done_pulse", done_valid, 1'b0);

    // ID exhaustion and reuse
    send_cmd(32'h0000_1000, 4'd0, 0, 1'b0);
    run_beats(4'd0, 32'hC0);
    send_cmd(32'h0000_2000, 4'd0, 0, 1'b1);
    run_beats(4'd0, 32'hC1);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_3000;
    #1 chk("exhaust_cmd_ready", cmd_ready, 1'b0);
    cyc();
    chk("exhaust_not_taken", AW_request, 1'b0);
    cmd_valid = 1'b0;
    send_b(1'b1, RESP_SLVERR);
    chk("exhaust_done_id", done_id, 1'b1);
    chk("exhaust_done_resp", done_resp, 2'd2);
    chk("exhaust_cmd_ready_back", cmd_ready, 1'b1);
    send_cmd(32'h0000_3000, 4'd0, 0, 1'b1);
    run_beats(4'd0, 32'hC2);
    chk("both_busy_cmd_ready", cmd_ready, 1'b0);

    // Free both, then a backpressured burst
    send_b(1'b0, RESP_OKAY);
    send_b(1'b1, RESP_DECERR);
    chk("free_done_resp", done_resp, 2'd3);
    send_cmd(32'h0000_4000, 4'd2, 0, 1'b0);
    sent = 0;
    for (int k = 0; k < 5; k++) begin
      wdata_valid = 1'b1;
      wdata       = 32'hB0 + 32'(sent);
      W_ready     = pat[k];
      #1;
      chk("bp_wdata_ready", wdata_ready, pat[k]);
      chk("bp_w_data", W_data, 32'hB0 + 32'(sent));
      chk("bp_w_last", W_last, (sent == 2));
      cyc();
      if (pat[k]) sent++;
    end
    wdata_valid = 1'b0;
    W_ready     = 1'b0;
    #1 chk("bp_state_idle", dbg_state, ST_IDLE);

    // Simultaneous free of ID 0 and allocation: new command must get ID 1
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_5000;
    cmd_len   = 4'd0;
    B_valid   = 1'b1;
    B_id      = 1'b0;
    B_resp    = RESP_EXOKAY;
    #1 chk("simul_cmd_ready", cmd_ready, 1'b1);
    cyc();
    cmd_valid = 1'b0;
    B_valid   = 1'b0;
    #1;
    chk("simul_aw_id", AW_id, 1'b1);
    chk("simul_done_valid", done_valid, 1'b1);
    chk("simul_done_id", done_id, 1'b0);
    chk("simul_done_resp", done_resp, 2'd1);
    AW_grant = 1'b1;
    cyc();
    AW_grant = 1'b0;
    run_beats(4'd0, 32'hD0);
    chk("simul_id0_free", cmd_ready, 1'b1);
    chk("spur_still_set", spurious_b, 1'b1);

    // Reset mid-burst: ID 0 reallocated here, then reset on beat 2
    send_cmd(32'h0000_6000, 4'd3, 0, 1'b0);
    wdata_valid = 1'b1;
    wdata       = 32'hE0;
    W_ready     = 1'b1;
    cyc();
    wdata = 32'hE1;
    clr   = 1'b0;
    cyc();
    chk("mrst_cmd_ready", cmd_ready, 1'b0);
    chk("mrst_aw_request", AW_request, 1'b0);
    chk("mrst_aw_addr", AW_addr, 32'h0);
    chk("mrst_aw_id", AW_id, 1'b0);
    chk("mrst_w_valid", W_valid, 1'b0);
    chk("mrst_w_last", W_last, 1'b0);
    chk("mrst_done_valid", done_valid, 1'b0);
    chk("mrst_spurious", spurious_b, 1'b0);
    chk("mrst_state", dbg_state, ST_IDLE);
    clr         = 1'b1;
    wdata_valid = 1'b0;
    W_ready     = 1'b0;
    send_cmd(32'h0000_7000, 4'd1, 0, 1'b0);
    run_beats(4'd1, 32'hF0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
